// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between instruction fetch (IF) and data load/store
// (D). D has priority. IF wins the next arbitration once it has lost
// STARVE_MAX arbitrations in a row. Each transaction takes the sequence
// IDLE (grant) -> ACCESS (memory busy, waits on mem_ready) -> RESP (rvalid).
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   if_req/if_addr/if_gnt      fetch request, address and grant pulse
//   if_rvalid/if_rdata         fetch response pulse and instruction word
//   d_req/d_we/d_addr/d_wdata  data request (store when d_we=1)
//   d_gnt                      data grant pulse
//   d_rvalid/d_rdata/d_err     data response; d_err marks a misaligned access
//   mem_en/mem_we/mem_addr/mem_wdata   memory request, driven only in ACCESS
//   mem_rdata/mem_ready        memory read data and access-complete strobe
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic grant_if, grant_d, d_misaligned;
    logic if_gnt_c, d_gnt_c;

    // Fetch addresses are word aligned by construction; low bits are dropped.
    logic unused_if_addr_lsb;
    assign unused_if_addr_lsb = &{1'b0, if_addr[1:0]};

    assign grant_if     = if_req && (!d_req || (starve_cnt_q >= STARVE_LIM));
    assign grant_d      = d_req && !grant_if;
    assign d_misaligned = (d_addr[1:0] != 2'b00);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_gnt_c     = 1'b0;
        d_gnt_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    if_gnt_c     = 1'b1;
                    owner_d      = OWN_IF;
                    addr_d       = {if_addr[ADDR_W-1:2], 2'b00};
                    we_d         = 1'b0;
                    wdata_d      = '0;
                    err_d        = 1'b0;
                    starve_cnt_d = 4'd0;
                    state_d      = ACCESS;
                end else if (grant_d) begin
                    d_gnt_c = 1'b1;
                    owner_d = OWN_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    err_d   = d_misaligned;
                    // IF lost this round only if it was actually asking.
                    if (if_req)
                        starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
                    else
                        starve_cnt_d = 4'd0;
                    // Misaligned accesses never touch memory; answer at once.
                    if (d_misaligned) begin
                        d_rdata_d = '0;
                        state_d   = RESP;
                    end else begin
                        state_d   = ACCESS;
                    end
                end else begin
                    starve_cnt_d = 4'd0;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    if (owner_q == OWN_IF)
                        if_rdata_d = mem_rdata;
                    else
                        d_rdata_d = we_q ? '0 : mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            owner_q      <= OWN_IF;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Grants are issued in the arbitration cycle itself; mask them while
    // reset is held so every output is quiet during reset.
    assign if_gnt = if_gnt_c && !reset;
    assign d_gnt  = d_gnt_c && !reset;

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;

    assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
    assign d_rvalid  = (state_q == RESP) && (owner_q == OWN_D);
    assign d_err     = (state_q == RESP) && (owner_q == OWN_D) && err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between two requesters: instruction fetch (IF, driven from the program counter) and data load/store (D, driven by control-unit load_on/store_on).
- Fixed data priority with an IF anti-starvation override.
- Registered request/grant/response handshake.
- Sits between program_counter/control_unit and the unified memory in processor.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive lost arbitrations after which IF wins the next arbitration. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address; stable while if_req && !if_gnt.
- if_gnt  out  1  one-cycle pulse; fetch accepted.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse; data request accepted.
- d_rvalid  out  1  one-cycle pulse; load data valid, or store acknowledged.
- d_rdata  out  DATA_W  load data; 0 for stores.
- d_err  out  1  qualifies d_rvalid; misaligned access.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; sampled when mem_ready is high.
- mem_ready  in  1  memory completes the current access this cycle.

Behaviour:
- Reset (async, active-high): FSM = IDLE, starve_cnt = 0, owner = IF, and every output = 0. Reset mid-operation abandons the transaction: no rvalid, no further memory write after release.
- States: IDLE, ACCESS, RESP.
- IDLE arbitration, evaluated each cycle:
  - No request: stay in IDLE.
  - If if_req && (!d_req || starve_cnt >= STARVE_MAX): grant IF.
  - Else if d_req: grant D.
- On grant:
  - Pulse the matching gnt for one cycle, in the arbitration cycle.
  - Latch owner, address, we and wdata into internal registers.
  - Next state = ACCESS.
- Misaligned D (d_addr[1:0] != 0):
  - d_gnt pulses and the request is latched with an error flag.
  - No memory access is made; next state = RESP directly with d_err = 1.
- IF addresses are always word-aligned by construction. if_addr[1:0] is ignored and forced to 0 on mem_addr.
- ACCESS:
  - mem_en = 1; mem_we/mem_addr/mem_wdata driven from the latched registers and held stable.
  - Stay until mem_ready = 1. On mem_ready, capture mem_rdata (loads/fetches) and go to RESP.
  - mem_ready high in the first ACCESS cycle is legal (zero-wait memory).
  - mem_ready outside ACCESS is ignored.
- RESP:
  - Pulse the owner's rvalid for one cycle; rdata is registered and valid with it.
  - For a store: d_rvalid = 1, d_rdata = 0.
  - Next state = IDLE.
- Minimum transaction = 3 cycles (grant, access, resp). Back-to-back issue interval = 3 cycles with a zero-wait memory.
- No new grant is issued while in ACCESS or RESP. Requests raised meanwhile are held by the requester and arbitrated in the next IDLE cycle.
- starve_cnt, updated only in IDLE cycles:
  - IF granted, or if_req = 0: clear to 0.
  - if_req = 1 and D granted: increment, saturating at 15.
- Simultaneous if_req && d_req with starve_cnt < STARVE_MAX: D wins.
- rdata outputs hold their last value between rvalid pulses. mem_wdata and mem_addr = 0 outside ACCESS.
- d_err = 0 except during d_rvalid of a misaligned request.

Test Plan:
- Reset: reset = 1 mid-ACCESS (store 0x0000_0010 pending, mem_ready = 0) -> all outputs 0 next cycle, no d_rvalid after release, FSM IDLE.
- Single fetch: if_req = 1, if_addr = 0x0000_0004, mem_ready = 1 on the first ACCESS cycle, mem_rdata = 0x0040_0093 -> if_gnt at cycle 0, mem_en = 1 at cycle 1, if_rvalid = 1 with if_rdata = 0x0040_0093 at cycle 2.
- Contention: if_req and d_req both high, d_we = 0, d_addr = 0x0000_0100 -> d_gnt first; IF granted in the next IDLE cycle (cycle 3) with zero-wait memory.
- Starvation: if_req held high and d_req re-raised every IDLE for 6 arbitrations, STARVE_MAX = 4 -> the 5th arbitration grants IF, and starve_cnt returns to 0.
- Wait states: store to 0x0000_0020, wdata = 0xDEAD_BEEF, mem_ready delayed 3 cycles -> mem_en, mem_we, mem_addr and mem_wdata stable for all 3 cycles; d_rvalid = 1 and d_rdata = 0 the cycle after mem_ready.
- Misaligned: d_req = 1, d_addr = 0x0000_0102 -> d_gnt, mem_en never asserted, next cycle d_rvalid = 1 and d_err = 1.
